// File: rtl/glitch_free_clk_div.sv
// ============================================================================
// Module      : glitch_free_clk_div
// Description : Flop-driven divided clock with period-aligned ratio updates
//               and stop/park-low control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module glitch_free_clk_div #(
    parameter int DIV_W     = 8,
    parameter int DEF_RATIO = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             div_req_valid,
    input  logic [DIV_W-1:0] div_req_ratio,
    output logic             div_req_ready,
    output logic             div_ack,
    input  logic             stop,
    output logic             clk_out,
    output logic             clk_en,
    output logic [DIV_W-1:0] cur_ratio,
    output logic             stopped
);

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] C_DEF_RATIO = DIV_W'(DEF_RATIO);
    localparam logic [DIV_W-1:0] C_ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] C_TWO       = DIV_W'(2);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             clk_en_q, clk_en_d;
    logic [DIV_W-1:0] cur_ratio_q, cur_ratio_d;
    logic             pend_vld_q, pend_vld_d;
    logic [DIV_W-1:0] pend_ratio_q, pend_ratio_d;
    logic             div_ack_q, div_ack_d;
    logic             ready_q, ready_d;
    logic             stopped_q, stopped_d;

    logic [DIV_W-1:0] w_clamped;
    logic [DIV_W-1:0] w_hi;
    logic [DIV_W-1:0] w_last;
    logic [DIV_W-1:0] w_cnt_inc;
    logic             w_period_end;
    logic             w_boundary;
    logic             w_accept;

    assign w_clamped    = (div_req_ratio < C_TWO) ? C_TWO : div_req_ratio;
    assign w_hi         = cur_ratio_q >> 1;
    assign w_last       = cur_ratio_q - C_ONE;
    assign w_cnt_inc    = cnt_q + C_ONE;
    assign w_period_end = (cnt_q == w_last);
    assign w_boundary   = (state_q == ST_STOPPED) || w_period_end;
    assign w_accept     = div_req_valid && !pend_vld_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        clk_en_d     = 1'b0;
        cur_ratio_d  = cur_ratio_q;
        pend_vld_d   = pend_vld_q;
        pend_ratio_d = pend_ratio_q;
        div_ack_d    = 1'b0;

        // Uses the pre-edge pending bit, so a request landing on this same
        // edge is held for the following boundary.
        if (w_boundary && pend_vld_q) begin
            cur_ratio_d = pend_ratio_q;
            pend_vld_d  = 1'b0;
            div_ack_d   = 1'b1;
        end

        if (w_accept) begin
            pend_vld_d   = 1'b1;
            pend_ratio_d = w_clamped;
        end

        case (state_q)
            ST_STOPPED: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (!stop) begin
                    state_d   = ST_RUN;
                    clk_out_d = 1'b1;
                    clk_en_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_period_end) begin
                    cnt_d = '0;
                    if (stop) begin
                        state_d   = ST_STOPPED;
                        clk_out_d = 1'b0;
                    end else begin
                        clk_out_d = 1'b1;
                        clk_en_d  = 1'b1;
                    end
                end else begin
                    cnt_d     = w_cnt_inc;
                    clk_out_d = (w_cnt_inc < w_hi);
                end
            end
            default: begin
                state_d   = ST_STOPPED;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        stopped_d = (state_d == ST_STOPPED);
        ready_d   = !pend_vld_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_STOPPED;
            cnt_q        <= '0;
            clk_out_q    <= 1'b0;
            clk_en_q     <= 1'b0;
            cur_ratio_q  <= C_DEF_RATIO;
            pend_vld_q   <= 1'b0;
            pend_ratio_q <= C_DEF_RATIO;
            div_ack_q    <= 1'b0;
            ready_q      <= 1'b1;
            stopped_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            clk_en_q     <= clk_en_d;
            cur_ratio_q  <= cur_ratio_d;
            pend_vld_q   <= pend_vld_d;
            pend_ratio_q <= pend_ratio_d;
            div_ack_q    <= div_ack_d;
            ready_q      <= ready_d;
            stopped_q    <= stopped_d;
        end
    end

    assign clk_out       = clk_out_q;
    assign clk_en        = clk_en_q;
    assign cur_ratio     = cur_ratio_q;
    assign div_ack       = div_ack_q;
    assign div_req_ready = ready_q;
    assign stopped       = stopped_q;

endmodule

`default_nettype wire

// File: tb/tb_glitch_free_clk_div.sv
// ============================================================================
// Module      : tb_glitch_free_clk_div
// Description : Directed self-checking bench for glitch_free_clk_div.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_glitch_free_clk_div;

    logic       clk;
    logic       rstn;
    logic       div_req_valid;
    logic [7:0] div_req_ratio;
    logic       div_req_ready;
    logic       div_ack;
    logic       stop;
    logic       clk_out;
    logic       clk_en;
    logic [7:0] cur_ratio;
    logic       stopped;

    int n_vec;
    int n_err;

    glitch_free_clk_div #(
        .DIV_W     (8),
        .DEF_RATIO (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .div_req_valid (div_req_valid),
        .div_req_ratio (div_req_ratio),
        .div_req_ready (div_req_ready),
        .div_ack       (div_ack),
        .stop          (stop),
        .clk_out       (clk_out),
        .clk_en        (clk_en),
        .cur_ratio     (cur_ratio),
        .stopped       (stopped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check the clock outputs mid-cycle on the falling edge.
    task automatic cyc(input string tag, input logic e_out, input logic e_en);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".clk_out"}, {31'd0, clk_out}, {31'd0, e_out});
        chk({tag, ".clk_en"},  {31'd0, clk_en},  {31'd0, e_en});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn = 1'b0;
        stop = 1'b0;
        div_req_valid = 1'b0;
        div_req_ratio = 8'd0;

        // Reset state
        cyc("rst0", 1'b0, 1'b0);
        cyc("rst1", 1'b0, 1'b0);
        chk("rst.stopped", {31'd0, stopped}, 32'd1);
        chk("rst.ready", {31'd0, div_req_ready}, 32'd1);
        chk("rst.cur_ratio", {24'd0, cur_ratio}, 32'd4);
        chk("rst.ack", {31'd0, div_ack}, 32'd0);

        // Default ratio 4: 1,1,0,0 repeating
        rstn = 1'b1;
        cyc("r4a0", 1'b1, 1'b1);
        chk("r4.stopped", {31'd0, stopped}, 32'd0);
        cyc("r4a1", 1'b1, 1'b0);
        cyc("r4a2", 1'b0, 1'b0);
        cyc("r4a3", 1'b0, 1'b0);
        cyc("r4b0", 1'b1, 1'b1);
        cyc("r4b1", 1'b1, 1'b0);
        cyc("r4b2", 1'b0, 1'b0);
        cyc("r4b3", 1'b0, 1'b0);

        // Ratio 5 requested at cnt==1
        cyc("r4c0", 1'b1, 1'b1);
        cyc("r4c1", 1'b1, 1'b0);
        div_req_valid = 1'b1;
        div_req_ratio = 8'd5;
        cyc("r4c2", 1'b0, 1'b0);
        div_req_valid = 1'b0;
        chk("r5.ready_low", {31'd0, div_req_ready}, 32'd0);
        cyc("r4c3", 1'b0, 1'b0);
        chk("r5.ready_low2", {31'd0, div_req_ready}, 32'd0);
        chk("r5.cur_old", {24'd0, cur_ratio}, 32'd4);
        chk("r5.no_ack_yet", {31'd0, div_ack}, 32'd0);
        cyc("r5a0", 1'b1, 1'b1);
        chk("r5.ack", {31'd0, div_ack}, 32'd1);
        chk("r5.cur_new", {24'd0, cur_ratio}, 32'd5);
        chk("r5.ready_back", {31'd0, div_req_ready}, 32'd1);
        cyc("r5a1", 1'b1, 1'b0);
        chk("r5.ack_once", {31'd0, div_ack}, 32'd0);
        cyc("r5a2", 1'b0, 1'b0);
        cyc("r5a3", 1'b0, 1'b0);
        cyc("r5a4", 1'b0, 1'b0);
        cyc("r5b0", 1'b1, 1'b1);

        // Ratio 0 clamps to 2
        div_req_valid = 1'b1;
        div_req_ratio = 8'd0;
        cyc("r5b1", 1'b1, 1'b0);
        div_req_valid = 1'b0;
        cyc("r5b2", 1'b0, 1'b0);
        cyc("r5b3", 1'b0, 1'b0);
        cyc("r5b4", 1'b0, 1'b0);
        cyc("r2a0", 1'b1, 1'b1);
        chk("r0.ack", {31'd0, div_ack}, 32'd1);
        chk("r0.cur", {24'd0, cur_ratio}, 32'd2);
        cyc("r2a1", 1'b0, 1'b0);
        cyc("r2b0", 1'b1, 1'b1);
        cyc("r2b1", 1'b0, 1'b0);

        // Ratio 1 accepted on a boundary edge: held one more period
        div_req_valid = 1'b1;
        div_req_ratio = 8'd1;
        cyc("r2c0", 1'b1, 1'b1);
        chk("r1.no_ack", {31'd0, div_ack}, 32'd0);
        chk("r1.ready_low", {31'd0, div_req_ready}, 32'd0);
        div_req_ratio = 8'd9;
        cyc("r2c1", 1'b0, 1'b0);
        chk("r9.rejected_ready", {31'd0, div_req_ready}, 32'd0);
        div_req_valid = 1'b0;
        cyc("r2d0", 1'b1, 1'b1);
        chk("r1.ack", {31'd0, div_ack}, 32'd1);
        chk("r1.cur", {24'd0, cur_ratio}, 32'd2);
        chk("r9.not_pending", {31'd0, div_req_ready}, 32'd1);
        cyc("r2d1", 1'b0, 1'b0);
        chk("r9.no_ack", {31'd0, div_ack}, 32'd0);
        chk("r9.cur_still2", {24'd0, cur_ratio}, 32'd2);

        // Ratio 6 then stop requested at cnt==0
        div_req_valid = 1'b1;
        div_req_ratio = 8'd6;
        cyc("r2e0", 1'b1, 1'b1);
        div_req_valid = 1'b0;
        cyc("r2e1", 1'b0, 1'b0);
        cyc("r6a0", 1'b1, 1'b1);
        chk("r6.cur", {24'd0, cur_ratio}, 32'd6);
        stop = 1'b1;
        cyc("r6a1", 1'b1, 1'b0);
        cyc("r6a2", 1'b1, 1'b0);
        cyc("r6a3", 1'b0, 1'b0);
        cyc("r6a4", 1'b0, 1'b0);
        cyc("r6a5", 1'b0, 1'b0);
        chk("r6.not_stopped_yet", {31'd0, stopped}, 32'd0);
        cyc("stp0", 1'b0, 1'b0);
        chk("stp.stopped", {31'd0, stopped}, 32'd1);
        cyc("stp1", 1'b0, 1'b0);
        chk("stp.stopped2", {31'd0, stopped}, 32'd1);
        stop = 1'b0;
        cyc("rst6a0", 1'b1, 1'b1);
        chk("restart.stopped", {31'd0, stopped}, 32'd0);

        // Reset mid high phase with ratio 7 pending
        div_req_valid = 1'b1;
        div_req_ratio = 8'd7;
        cyc("r6b1", 1'b1, 1'b0);
        div_req_valid = 1'b0;
        chk("r7.pending", {31'd0, div_req_ready}, 32'd0);
        rstn = 1'b0;
        cyc("mrst0", 1'b0, 1'b0);
        chk("mrst.cur", {24'd0, cur_ratio}, 32'd4);
        chk("mrst.ack", {31'd0, div_ack}, 32'd0);
        chk("mrst.ready", {31'd0, div_req_ready}, 32'd1);
        chk("mrst.stopped", {31'd0, stopped}, 32'd1);
        rstn = 1'b1;
        cyc("pr0", 1'b1, 1'b1);
        chk("pr.ack", {31'd0, div_ack}, 32'd0);
        cyc("pr1", 1'b1, 1'b0);
        cyc("pr2", 1'b0, 1'b0);
        cyc("pr3", 1'b0, 1'b0);
        cyc("pr4", 1'b1, 1'b1);
        chk("pr.cur", {24'd0, cur_ratio}, 32'd4);
        chk("pr.no_ack", {31'd0, div_ack}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/glitch_free_clk_div.md
GLITCH_FREE_CLK_DIV -- requirements
Module: glitch_free_clk_div

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the divide ratio.
REQ-002 SHALL have parameter DEF_RATIO, default 4: ratio loaded at reset (2..2^DIV_W-1).
REQ-003 clk  input  1  sole clock; all flops on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 div_req_valid  input  1  new-ratio request valid.
REQ-006 div_req_ratio  input  DIV_W  requested divide ratio.
REQ-007 div_req_ready  output  1  request accepted when valid && ready at clk edge.
REQ-008 div_ack  output  1  one-cycle pulse when the accepted ratio takes effect.
REQ-009 stop  input  1  level; request output clock parked low.
REQ-010 clk_out  output  1  divided clock, driven directly by a flop.
REQ-011 clk_en  output  1  one-cycle pulse coincident with each clk_out rising cycle.
REQ-012 cur_ratio  output  DIV_W  ratio currently in effect.
REQ-013 stopped  output  1  high while in STOPPED state.

Function
REQ-014 State machine SHALL have two states, STOPPED and RUN, plus a pending-ratio register with valid bit pend_vld.
REQ-015 Effective ratio R SHALL be the requested value clamped: 0 or 1 -> 2; else unchanged.
REQ-016 hi = R>>1; in RUN each period SHALL be R cycles: clk_out high for hi cycles, then low for R-hi cycles (R=3 -> 1 high, 2 low).
REQ-017 Period counter cnt SHALL count 0..R-1; clk_out = 1 exactly in cycles where cnt < hi; all outputs SHALL be flop outputs (no combinational path to clk_out).
REQ-018 div_req_ready SHALL equal !pend_vld; accepted request sets pend_vld and stores clamped ratio.
REQ-019 Period boundary = RUN with cnt==R-1, or any cycle in STOPPED.
REQ-020 At a boundary with pend_vld set, cur_ratio SHALL load the pending ratio, pend_vld SHALL clear, div_ack SHALL pulse in the next cycle.
REQ-021 A request accepted on the same edge as a boundary SHALL NOT be applied at that boundary; it waits for the next one.
REQ-022 Ratio SHALL never change mid-period: no shortened high or low phase, no runt pulse.
REQ-023 STOPPED -> RUN on edge where stop==0: cnt<=0, clk_out<=1, clk_en<=1.
REQ-024 RUN at cnt==R-1 with stop==1 -> STOPPED: clk_out stays 0; otherwise cnt<=0, clk_out<=1, clk_en<=1.
REQ-025 stop asserted mid-period SHALL NOT truncate the period; stop deasserted before period end SHALL have no effect.
REQ-026 In STOPPED clk_out and clk_en SHALL be 0; stopped SHALL be 1.
REQ-027 div_ack and clk_en SHALL never be high for more than one consecutive cycle.

Reset
REQ-028 While rstn==0 at an edge: state=STOPPED, cnt=0, clk_out=0, clk_en=0, cur_ratio=DEF_RATIO, pend_vld=0, div_ack=0; div_req_ready=1, stopped=1 after that edge.
REQ-029 Reset asserted mid-period SHALL abort immediately to reset values; pending request SHALL be discarded without ack.
REQ-030 First edge with rstn==1 and stop==0 SHALL start RUN per REQ-023.

Verification
REQ-031 Reset release, stop=0, DEF_RATIO=4 -> clk_out pattern 1,1,0,0 repeating; clk_en high on each first '1'; stopped=0.
REQ-032 Request ratio 5 at cnt==1 of a ratio-4 period -> current period completes as 1,1,0,0; next period 1,1,0,0,0; div_ack pulses once in the cycle after that boundary; ready low from acceptance until boundary.
REQ-033 Request ratio 0 and ratio 1 -> cur_ratio becomes 2; clk_out toggles 1,0 every cycle.
REQ-034 stop=1 at cnt==0 of ratio 6 -> full 1,1,1,0,0,0 completes, then clk_out held 0, stopped=1; stop=0 -> clk_out rises on next edge.
REQ-035 Request accepted on the same edge as a period end -> applied only at the following boundary; second request while pend_vld=1 -> ready=0, not accepted.
REQ-036 rstn=0 mid high phase with pending ratio 7 -> clk_out=0 after edge, cur_ratio=4, no div_ack.
